// File: rtl/mcu_output_scheduler.sv
// Per-sample sequencer for the MCU SPI output path: walks the enabled roll/pitch/yaw
// channels in order, pulsing write_enable and waiting (with timeout) for the MCU done handshake.
module mcu_output_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TO_BITS        = 12
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       configured_in,
    input  logic       sample_valid_in,
    input  logic [2:0] enable_mask_in,
    input  logic       done_in,
    input  logic       clear_overrun_in,
    output logic       write_enable_out,
    output logic [1:0] output_select_out,
    output logic       busy_out,
    output logic       frame_done_out,
    output logic       timeout_out,
    output logic       overrun_out
);

    localparam int unsigned         CH_BITS = 2;
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

    generate
        if (TIMEOUT_CYCLES < 2 || ((TIMEOUT_CYCLES - 1) >> TO_BITS) != 0) begin : g_bad_params
            $error("mcu_output_scheduler: TIMEOUT_CYCLES must be >= 2 and fit in TO_BITS");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_UNCONF,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_FEND
    } state_t;

    state_t             state;
    logic [2:0]         mask;
    logic [TO_BITS-1:0] to_cnt;

    logic               first_found;
    logic [CH_BITS-1:0] first_sel;
    logic               next_found;
    logic [CH_BITS-1:0] next_sel;
    logic [2:0]         above;
    logic [2:0]         remaining;

    // Lowest enabled channel of an incoming sample's mask.
    always_comb begin
        first_found = |enable_mask_in;
        first_sel   = 2'd0;
        if (enable_mask_in[0]) begin
            first_sel = 2'd0;
        end else if (enable_mask_in[1]) begin
            first_sel = 2'd1;
        end else if (enable_mask_in[2]) begin
            first_sel = 2'd2;
        end
    end

    // Next enabled channel strictly after the one currently selected.
    always_comb begin
        above = 3'b000;
        case (output_select_out)
            2'd0:    above = 3'b110;
            2'd1:    above = 3'b100;
            default: above = 3'b000;
        endcase
        remaining  = mask & above;
        next_found = |remaining;
        next_sel   = 2'd0;
        if (remaining[1]) begin
            next_sel = 2'd1;
        end else if (remaining[2]) begin
            next_sel = 2'd2;
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state             <= ST_UNCONF;
            mask              <= 3'b000;
            to_cnt            <= '0;
            write_enable_out  <= 1'b0;
            output_select_out <= 2'b00;
            busy_out          <= 1'b0;
            frame_done_out    <= 1'b0;
            timeout_out       <= 1'b0;
            overrun_out       <= 1'b0;
        end else begin
            write_enable_out <= 1'b0;
            frame_done_out   <= 1'b0;
            timeout_out      <= 1'b0;

            // A new overrun outranks a simultaneous clear.
            if (sample_valid_in && (state == ST_ISSUE || state == ST_WAIT_DONE)) begin
                overrun_out <= 1'b1;
            end else if (clear_overrun_in) begin
                overrun_out <= 1'b0;
            end

            case (state)
                ST_UNCONF: begin
                    if (configured_in) begin
                        state <= ST_IDLE;
                    end
                end

                ST_IDLE, ST_FEND: begin
                    if (sample_valid_in) begin
                        mask <= enable_mask_in;
                        if (first_found) begin
                            state             <= ST_ISSUE;
                            output_select_out <= first_sel;
                            write_enable_out  <= 1'b1;
                            busy_out          <= 1'b1;
                        end else begin
                            state          <= ST_FEND;
                            frame_done_out <= 1'b1;
                            busy_out       <= 1'b0;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_ISSUE: begin
                    state  <= ST_WAIT_DONE;
                    to_cnt <= '0;
                end

                ST_WAIT_DONE: begin
                    // Terminal count without done abandons the channel; done always wins.
                    if (done_in || to_cnt == TO_LAST) begin
                        timeout_out <= ~done_in;
                        if (next_found) begin
                            state             <= ST_ISSUE;
                            output_select_out <= next_sel;
                            write_enable_out  <= 1'b1;
                        end else begin
                            state          <= ST_FEND;
                            frame_done_out <= 1'b1;
                            busy_out       <= 1'b0;
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_BITS'(1);
                    end
                end

                default: begin
                    state <= ST_UNCONF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_output_scheduler.sv
// Self-checking bench for mcu_output_scheduler: frame timelines are predicted from per-channel
// done delays with plain arithmetic, then compared cycle by cycle.
module tb_mcu_output_scheduler;

    localparam int TO    = 8;
    localparam int NEVER = 1000;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       configured_in;
    logic       sample_valid_in;
    logic [2:0] enable_mask_in;
    logic       done_in;
    logic       clear_overrun_in;
    logic       write_enable_out;
    logic [1:0] output_select_out;
    logic       busy_out;
    logic       frame_done_out;
    logic       timeout_out;
    logic       overrun_out;

    mcu_output_scheduler #(.TIMEOUT_CYCLES(TO), .TO_BITS(4)) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .configured_in     (configured_in),
        .sample_valid_in   (sample_valid_in),
        .enable_mask_in    (enable_mask_in),
        .done_in           (done_in),
        .clear_overrun_in  (clear_overrun_in),
        .write_enable_out  (write_enable_out),
        .output_select_out (output_select_out),
        .busy_out          (busy_out),
        .frame_done_out    (frame_done_out),
        .timeout_out       (timeout_out),
        .overrun_out       (overrun_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mask;
        int         d0;
        int         d1;
        int         d2;
        bit         chain;
        int         n_we;
        int         len;
        int         n_to;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    logic       exp_ov;
    logic [1:0] last_sel;
    logic       prev_sv, prev_clr, prev_busy;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input logic e_we, input logic [1:0] e_sel, input logic e_busy,
                             input logic e_fd, input logic e_to);
        chk("write_enable", int'(write_enable_out), int'(e_we));
        chk("output_select", int'(output_select_out), int'(e_sel));
        chk("busy", int'(busy_out), int'(e_busy));
        chk("frame_done", int'(frame_done_out), int'(e_fd));
        chk("timeout", int'(timeout_out), int'(e_to));
        chk("overrun", int'(overrun_out), int'(exp_ov));
    endtask

    // in_frame marks a cycle the model places inside a frame (issue or waiting for done).
    task automatic drive(input logic sv, input logic [2:0] m, input logic d, input logic clr,
                         input logic in_frame);
        sample_valid_in  = sv;
        enable_mask_in   = m;
        done_in          = d;
        clear_overrun_in = clr;
        prev_sv          = sv;
        prev_clr         = clr;
        prev_busy        = in_frame;
    endtask

    task automatic tick();
        @(posedge clk);
        if (prev_sv && prev_busy) exp_ov = 1'b1;
        else if (prev_clr) exp_ov = 1'b0;
        #1;
    endtask

    task automatic idle(input int cycles, input bit rand_clr);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check_all(1'b0, last_sel, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 3'($urandom), 1'($urandom), rand_clr && ($urandom_range(2) == 0), 1'b0);
        end
    endtask

    // Starts a frame in the current cycle (DUT idle or in frame-end) and follows it to frame end.
    // d0..d2: cycles after that channel's write_enable at which done is pulsed (> TO means timeout).
    task automatic do_frame(input logic [2:0] m, input int d0, input int d1, input int d2,
                            input bit inject, input int ovc,
                            output int n_we, output int n_to, output int fd_at);
        int         ch[3];
        int         c[3];
        int         dl[3];
        int         dd[3];
        int         n;
        int         fin;
        logic       e_we, e_to, e_busy, e_fd, d_now, sv, clr;
        logic [1:0] e_sel;
        dd  = '{d0, d1, d2};
        ch  = '{0, 0, 0};
        c   = '{0, 0, 0};
        dl  = '{0, 0, 0};
        n   = 0;
        for (int i = 0; i < 3; i++) begin
            if (m[i]) begin
                ch[n] = i;
                dl[n] = dd[i];
                n++;
            end
        end
        fin = 1;
        for (int k = 0; k < n; k++) begin
            c[k] = fin;
            fin  = c[k] + ((dl[k] < TO) ? dl[k] : TO) + 1;
        end
        drive(1'b1, m, 1'b0, 1'b0, 1'b0);
        n_we  = 0;
        n_to  = 0;
        fd_at = -1;
        for (int t = 1; t <= fin; t++) begin
            tick();
            e_we  = 1'b0;
            e_to  = 1'b0;
            d_now = 1'b0;
            e_sel = last_sel;
            for (int k = 0; k < n; k++) begin
                if (t == c[k]) e_we = 1'b1;
                if (t >= c[k]) e_sel = 2'(ch[k]);
                if (dl[k] > TO && t == c[k] + TO + 1) e_to = 1'b1;
                if (t == c[k] + dl[k]) d_now = 1'b1;
            end
            e_busy = (t < fin);
            e_fd   = (t == fin);
            check_all(e_we, e_sel, e_busy, e_fd, e_to);
            n_we += int'(write_enable_out);
            n_to += int'(timeout_out);
            if (frame_done_out && fd_at < 0) fd_at = t;
            sv  = inject && e_busy && ($urandom_range(3) == 0);
            clr = ($urandom_range(5) == 0);
            if (t == ovc) begin
                sv  = 1'b1;
                clr = 1'b1;
            end
            drive(sv, 3'($urandom), d_now, clr, e_busy);
        end
        if (n > 0) last_sel = 2'(ch[n-1]);
    endtask

    function automatic int rnd_delay();
        int r;
        r = int'($urandom_range(9));
        if (r < 8) return r + 1;
        if (r == 8) return TO + 1;
        return NEVER;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        int   n_we, n_to, fd_at;
        vecs[0] = '{3'b111, 5, 5, 5, 1'b0, 3, 19, 0};
        vecs[1] = '{3'b101, 3, NEVER, 4, 1'b0, 2, 10, 0};
        vecs[2] = '{3'b000, 1, 1, 1, 1'b1, 0, 1, 0};
        vecs[3] = '{3'b011, NEVER, 2, 1, 1'b0, 2, 13, 1};
        vecs[4] = '{3'b011, 8, 2, 1, 1'b1, 2, 13, 0};
        vecs[5] = '{3'b100, 1, 1, 1, 1'b0, 1, 3, 0};
        vecs[6] = '{3'b110, 1, 9, 9, 1'b1, 2, 19, 2};
        vecs[7] = '{3'b010, 1, 1, 1, 1'b0, 1, 3, 0};

        n_rst         = 1'b1;
        configured_in = 1'b0;
        exp_ov        = 1'b0;
        last_sel      = 2'b00;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_all(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b0;

        // Unconfigured: samples and done are ignored, no overrun.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b111, 1'b1, 1'b0, 1'b0);
            tick();
            check_all(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        configured_in = 1'b1;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        check_all(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

        // Sample on the very next cycle must already be accepted.
        do_frame(3'b001, 2, 1, 1, 1'b0, -1, n_we, n_to, fd_at);
        chk("first_frame_len", fd_at, 4);

        for (int i = 0; i < 8; i++) begin
            if (!vecs[i].chain) idle(2, 1'b0);
            do_frame(vecs[i].mask, vecs[i].d0, vecs[i].d1, vecs[i].d2, 1'b0, -1, n_we, n_to, fd_at);
            chk("tbl_we_count", n_we, vecs[i].n_we);
            chk("tbl_frame_len", fd_at, vecs[i].len);
            chk("tbl_timeouts", n_to, vecs[i].n_to);
            if (vecs[i].chain) chk("chain_no_overrun", int'(overrun_out), 0);
        end

        // Overrun together with clear: set wins, frame unaffected; clear alone then drops it.
        idle(1, 1'b0);
        drive(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        do_frame(3'b001, 6, 1, 1, 1'b0, 3, n_we, n_to, fd_at);
        chk("overrun_frame_len", fd_at, 8);
        chk("overrun_set_wins", int'(overrun_out), 1);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("overrun_sticky", int'(overrun_out), 1);
        drive(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        chk("overrun_cleared", int'(overrun_out), 0);

        // Randomized frames with random delays, chaining, overruns and clears.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1) == 0) idle(int'($urandom_range(1, 3)), 1'b1);
            do_frame(3'($urandom), rnd_delay(), rnd_delay(), rnd_delay(), 1'($urandom), -1,
                     n_we, n_to, fd_at);
        end
        idle(2, 1'b0);

        // Asynchronous reset while waiting for done.
        drive(1'b1, 3'b110, 1'b0, 1'b0, 1'b0);
        tick();
        check_all(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        check_all(1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        chk("pre_reset_overrun", int'(overrun_out), 1);
        #2;
        n_rst = 1'b1;
        #1;
        exp_ov   = 1'b0;
        last_sel = 2'b00;
        configured_in = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        check_all(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
            tick();
            check_all(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        configured_in = 1'b1;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        do_frame(3'b111, 1, 2, 3, 1'b0, -1, n_we, n_to, fd_at);
        chk("post_reset_we_count", n_we, 3);
        chk("post_reset_len", fd_at, 10);
        idle(2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
